// File: rtl/debounce_pkg.sv
// Shared constants for the input debouncer: FSM state encoding and parameter limits.
// The busy states are exactly those whose two encoding bits differ.
package debounce_pkg;

   localparam logic [1:0] S_LOW_ENC     = 2'b00;
   localparam logic [1:0] S_TO_HIGH_ENC = 2'b01;
   localparam logic [1:0] S_HIGH_ENC    = 2'b11;
   localparam logic [1:0] S_TO_LOW_ENC  = 2'b10;

   typedef enum logic [1:0] {
      S_LOW     = S_LOW_ENC,
      S_TO_HIGH = S_TO_HIGH_ENC,
      S_HIGH    = S_HIGH_ENC,
      S_TO_LOW  = S_TO_LOW_ENC
   } state_t;

   localparam int SYNC_STAGES_MIN     = 2;
   localparam int DEBOUNCE_CYCLES_MIN = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous level; q lags d by STAGES clocks.
// Reset clears every stage, so an undriven input cannot reach q during reset.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a bouncy async level and commits it after DEBOUNCE_CYCLES stable samples.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES clocks; outputs registered, no backpressure.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic A_raw,
   output logic A,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("input_debouncer: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
   end
   if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_deb
      $error("input_debouncer: DEBOUNCE_CYCLES must be at least %0d", DEBOUNCE_CYCLES_MIN);
   end

   logic s_in;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (A_raw),
      .q     (s_in)
   );

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_q, a_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (s_in) begin
               state_d = S_TO_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         S_TO_HIGH: begin
            // A single contrary sample aborts and restarts qualification from zero.
            if (!s_in) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_HIGH;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!s_in) begin
               state_d = S_TO_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         S_TO_LOW: begin
            if (s_in) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_LOW;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
         end
      endcase
      a_d    = (state_d == S_HIGH) || (state_d == S_TO_LOW);
      busy_d = (state_d == S_TO_HIGH) || (state_d == S_TO_LOW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign A    = a_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: default instance plus a SYNC_STAGES=3/DEBOUNCE_CYCLES=8 instance,
// both checked every edge against a run-length model of the debounce rule.
module tb_input_debouncer;

   logic clk;
   logic rst_n;
   logic A_raw;
   logic a1, rise1, fall1, busy1;
   logic a2, rise2, fall2, busy2;

   input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .A_raw(A_raw),
      .A(a1), .rise(rise1), .fall(fall1), .busy(busy1)
   );

   input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .A_raw(A_raw),
      .A(a2), .rise(rise2), .fall(fall2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the committed level flips once DC consecutive synchronised samples disagree with it.
   typedef struct {
      logic [15:0] sync;
      int          run;
      logic        a;
      logic        rise;
      logic        fall;
   } model_t;

   typedef struct {
      logic       a_raw;
      logic [3:0] exp;
   } vec_t;

   model_t m1, m2;
   int     n_vec = 0;
   int     n_bad = 0;
   int     cnt1_max = 0;
   int     cnt2_max = 0;

   function automatic model_t mreset();
      model_t m;
      m.sync = '0;
      m.run  = 0;
      m.a    = 1'b0;
      m.rise = 1'b0;
      m.fall = 1'b0;
      return m;
   endfunction

   function automatic model_t mstep(model_t m_in, logic araw, int ss, int dc);
      model_t m;
      logic   v;
      m      = m_in;
      v      = m.sync[ss-1];
      m.sync = {m.sync[14:0], araw};
      m.rise = 1'b0;
      m.fall = 1'b0;
      if (v != m.a) begin
         m.run = m.run + 1;
         if (m.run == dc) begin
            m.a    = v;
            m.rise = v;
            m.fall = !v;
            m.run  = 0;
         end
      end else begin
         m.run = 0;
      end
      return m;
   endfunction

   function automatic logic [3:0] mexp(model_t m);
      return {m.a, m.rise, m.fall, (m.run != 0)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      if (int'(dut.cnt_q) > cnt1_max) cnt1_max = int'(dut.cnt_q);
      if (int'(dut2.cnt_q) > cnt2_max) cnt2_max = int'(dut2.cnt_q);
   end

   // Drive A_raw away from the edge, advance one edge, update models, sample 1 time unit later.
   task automatic tick(input logic a, input string tag);
      A_raw = a;
      @(posedge clk);
      if (rst_n) begin
         m1 = mstep(m1, a, 2, 4);
         m2 = mstep(m2, a, 3, 8);
      end
      #1;
      chk({tag, "/d1"}, int'({a1, rise1, fall1, busy1}), int'(mexp(m1)));
      chk({tag, "/d2"}, int'({a2, rise2, fall2, busy2}), int'(mexp(m2)));
   endtask

   task automatic do_reset(input int cycles, input logic a);
      rst_n = 1'b0;
      m1 = mreset();
      m2 = mreset();
      for (int i = 0; i < cycles; i++) begin
         tick(a, "reset");
         chk("reset_zero", int'({a1, rise1, fall1, busy1, a2, rise2, fall2, busy2}), 0);
      end
      rst_n = 1'b1;
   endtask

   // Holds A_raw high straight after reset release and records the edge each instance commits.
   task automatic measure_commit(output int e1, output int e2);
      e1 = -1;
      e2 = -1;
      for (int e = 1; e <= 40; e++) begin
         tick(1'b1, "commit");
         if (a1 && e1 < 0) begin
            e1 = e;
            chk("commit_rise_d1", int'(rise1), 1);
         end
         if (a2 && e2 < 0) begin
            e2 = e;
            chk("commit_rise_d2", int'(rise2), 1);
         end
      end
   endtask

   initial begin
      vec_t vecs[15];
      int   e1, e2;
      int   busy_seen, rise_seen, fall_cnt, fall_rel;

      vecs = '{
         '{1'b1, 4'b0000}, '{1'b1, 4'b0000}, '{1'b1, 4'b0001}, '{1'b1, 4'b0001},
         '{1'b1, 4'b0001}, '{1'b1, 4'b1100}, '{1'b1, 4'b1000}, '{1'b1, 4'b1000},
         '{1'b0, 4'b1000}, '{1'b0, 4'b1000}, '{1'b0, 4'b1001}, '{1'b0, 4'b1001},
         '{1'b0, 4'b1001}, '{1'b0, 4'b0010}, '{1'b0, 4'b0000}
      };

      A_raw = 1'b1;
      rst_n = 1'b0;
      m1 = mreset();
      m2 = mreset();
      #3;
      chk("async_reset_zero", int'({a1, rise1, fall1, busy1}), 0);

      // Reset held with A_raw high, then clean press and clean release from the table.
      do_reset(3, 1'b1);
      for (int i = 0; i < 15; i++) begin
         tick(vecs[i].a_raw, "table");
         chk($sformatf("table_edge%0d", i + 1), int'({a1, rise1, fall1, busy1}), int'(vecs[i].exp));
      end

      // Latency of both instances from reset release with A_raw held high.
      do_reset(2, 1'b0);
      measure_commit(e1, e2);
      chk("latency_default", e1, 6);
      chk("latency_s3_d8", e2, 11);

      // Glitch of two samples from the low level.
      do_reset(2, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, "idle");
      busy_seen = 0;
      rise_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick(i < 2, "glitch");
         if (busy1) busy_seen++;
         if (rise1 || rise2 || a1 || a2) rise_seen++;
      end
      chk("glitch_busy_cycles", busy_seen, 2);
      chk("glitch_no_commit", rise_seen, 0);
      chk("glitch_back_low", int'(dut.state_q), 0);

      // Bouncy release from a committed high level.
      for (int i = 0; i < 14; i++) tick(1'b1, "hold_hi");
      chk("bounce_start_high", int'({a1, a2}), 3);
      fall_cnt = 0;
      fall_rel = -1;
      for (int i = 0; i < 16; i++) begin
         tick((i == 0 || i == 2), "bounce");
         if (fall1) begin
            fall_cnt++;
            fall_rel = i - 3 + 1;
         end
      end
      chk("bounce_one_fall", fall_cnt, 1);
      chk("bounce_fall_edge", fall_rel, 6);
      chk("bounce_final_low", int'(a1), 0);

      // Reset asserted between edges while qualifying a press with cnt==2.
      do_reset(2, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, "pre_abort");
      chk("abort_cnt_before", int'(dut.cnt_q), 2);
      chk("abort_busy_before", int'(busy1), 1);
      #2;
      rst_n = 1'b0;
      m1 = mreset();
      m2 = mreset();
      #1;
      chk("abort_cnt_cleared", int'(dut.cnt_q), 0);
      chk("abort_outputs_cleared", int'({a1, rise1, fall1, busy1}), 0);
      tick(1'b1, "abort_hold");
      rst_n = 1'b1;
      measure_commit(e1, e2);
      chk("abort_requalify_default", e1, 6);
      chk("abort_requalify_s3_d8", e2, 11);

      // Random bursts of varying length against the model.
      for (int b = 0; b < 60; b++) begin
         logic v;
         int   len;
         v   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) tick(v, "random");
      end

      chk("cnt_max_default", cnt1_max, 3);
      chk("cnt_max_s3_d8", cnt2_max, 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
